// File: rtl/play_sequencer_pkg.sv
// Shared types and constants for the song player.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, default field widths, mem_data field
// positions and the rest note code.
package play_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_PLAY  = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int DEF_NOTE_W = 10;
  localparam int DEF_DUR_W  = 8;
  localparam int DEF_ADDR_W = 8;

  // mem_data = {note, dur}: duration sits at bit 0, the note directly above
  // it (the note LSB therefore equals the duration width).
  localparam int DUR_LSB   = 0;
  localparam int NOTE_REST = 0;

endpackage

// File: rtl/play_tick_gen.sv
// Tick prescaler: divides clk by TICK_DIV into a 1-cycle tick.
// Latency: tick is combinational from the registered count (no extra stage).
// Backpressure: run low freezes the count; clr restarts it from zero.
//
// Ports: clk/rst (async, active-high), clr (restart count), run (count
// enable), tick (high on the last count of each period while running).
module play_tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Deliberately independent of clr: the caller derives clr from a next
  // state that itself depends on tick.
  assign tick = run && (cnt_q == LAST);

endmodule

// File: rtl/play_sequencer.sv
// Song player: fetches {note, dur} words over req/ack and times each note in ticks.
// Latency: all outputs registered; a fetched note sounds the cycle after mem_ack.
// Backpressure: mem_req held until mem_ack; pause freezes timing; enable low aborts.
//
// Ports: clk, rst (async, active-high); enable, start, pause, loop_en,
// song_len (control); mem_req/mem_addr/mem_ack/mem_data (song memory);
// note_out/note_valid (to synthesiser); busy, done (status).
module play_sequencer
  import play_pkg::*;
#(
  parameter int NOTE_W    = DEF_NOTE_W,
  parameter int DUR_W     = DEF_DUR_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int TICK_DIV  = 1_000_000,
  parameter int GAP_TICKS = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    loop_en,
  input  logic [ADDR_W-1:0]       song_len,
  output logic                    mem_req,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic                    mem_ack,
  input  logic [NOTE_W+DUR_W-1:0] mem_data,
  output logic [NOTE_W-1:0]       note_out,
  output logic                    note_valid,
  output logic                    busy,
  output logic                    done
);

  localparam int NOTE_LSB = DUR_W;
  localparam int GAP_W    = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] song_len_q, song_len_d;
  logic [NOTE_W-1:0] note_out_q, note_out_d;
  logic [DUR_W-1:0]  dur_cnt_q, dur_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              note_valid_q, note_valid_d;

  logic              advance;
  logic              tick, tick_clr, tick_run;
  logic [NOTE_W-1:0] word_note;
  logic [DUR_W-1:0]  word_dur;
  logic              last_entry;

  assign word_note  = mem_data[NOTE_LSB +: NOTE_W];
  assign word_dur   = mem_data[DUR_LSB +: DUR_W];
  assign last_entry = (addr_q == song_len_q - 1'b1);
  assign tick_run   = ((state_q == S_PLAY) || (state_q == S_GAP)) && !pause;

  play_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .run  (tick_run),
    .tick (tick)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    song_len_d = song_len_q;
    note_out_d = note_out_q;
    dur_cnt_d  = dur_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    mem_req_d  = mem_req_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    advance    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          song_len_d = song_len;
          if (song_len != '0) begin
            state_d   = S_FETCH;
            addr_d    = '0;
            busy_d    = 1'b1;
            mem_req_d = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_FETCH: begin
        if (!mem_req_q) begin
          // Re-issue after a skipped entry, once the new address is stable.
          mem_req_d = 1'b1;
        end else if (mem_ack) begin
          mem_req_d = 1'b0;
          if (word_dur == '0) begin
            advance = 1'b1;
          end else begin
            state_d    = S_PLAY;
            note_out_d = word_note;
            dur_cnt_d  = word_dur;
          end
        end
      end
      S_PLAY: begin
        if (tick) begin
          if (dur_cnt_q == DUR_W'(1)) begin
            note_out_d = '0;
            if (GAP_TICKS > 0) begin
              state_d   = S_GAP;
              gap_cnt_d = GAP_W'(GAP_TICKS);
            end else begin
              advance = 1'b1;
            end
          end else begin
            dur_cnt_d = dur_cnt_q - 1'b1;
          end
        end
      end
      S_GAP: begin
        if (tick) begin
          if (gap_cnt_q == GAP_W'(1)) begin
            advance = 1'b1;
          end else begin
            gap_cnt_d = gap_cnt_q - 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (advance) begin
      note_out_d = '0;
      if (last_entry && !loop_en) begin
        state_d = S_DONE;
      end else begin
        addr_d  = last_entry ? '0 : addr_q + 1'b1;
        state_d = S_FETCH;
        // From a skipped entry the request drops for one cycle so the
        // address never changes under a raised mem_req.
        mem_req_d = (state_q != S_FETCH);
      end
    end

    if (state_d == S_DONE) begin
      done_d     = 1'b1;
      busy_d     = 1'b0;
      mem_req_d  = 1'b0;
      note_out_d = '0;
    end

    // Abort wins over everything decided above, including a pending done.
    if (!enable) begin
      state_d    = S_IDLE;
      mem_req_d  = 1'b0;
      note_out_d = '0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
    end

    note_valid_d = (state_d == S_PLAY) && (note_out_d != NOTE_W'(NOTE_REST)) && !pause;
    tick_clr     = ((state_d == S_PLAY) || (state_d == S_GAP)) && (state_d != state_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      song_len_q   <= '0;
      note_out_q   <= '0;
      dur_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      mem_req_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      note_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      song_len_q   <= song_len_d;
      note_out_q   <= note_out_d;
      dur_cnt_q    <= dur_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      mem_req_q    <= mem_req_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      note_valid_q <= note_valid_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = addr_q;
  assign note_out   = note_out_q;
  assign note_valid = note_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_play_sequencer.sv
// Directed bench for play_sequencer with TICK_DIV=4, GAP_TICKS=1 and a
// song-memory model that acks one cycle after mem_req rises.
module tb_play_sequencer;

  localparam int NOTE_W    = 10;
  localparam int DUR_W     = 8;
  localparam int ADDR_W    = 8;
  localparam int TICK_DIV  = 4;
  localparam int GAP_TICKS = 1;

  logic                    clk, rst, enable, start, pause, loop_en;
  logic [ADDR_W-1:0]       song_len, mem_addr;
  logic                    mem_req, mem_ack, note_valid, busy, done;
  logic [NOTE_W+DUR_W-1:0] mem_data;
  logic [NOTE_W-1:0]       note_out;

  logic [NOTE_W+DUR_W-1:0] rom [0:7];
  logic mem_auto, force_ack, mon_clr;

  int hi_runs[$], lo_runs[$], addrs[$];
  int hi_len, lo_len, done_cnt, req_cnt, req_cyc;
  bit seen_hi, nv_prev;
  int checks, errors;

  play_sequencer #(
    .NOTE_W(NOTE_W), .DUR_W(DUR_W), .ADDR_W(ADDR_W),
    .TICK_DIV(TICK_DIV), .GAP_TICKS(GAP_TICKS)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .pause(pause),
    .loop_en(loop_en), .song_len(song_len), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data), .note_out(note_out),
    .note_valid(note_valid), .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Observer plus song-memory responder, both on the falling edge.
  initial begin
    mem_ack  = 1'b0;
    mem_data = '0;
    forever begin
      @(negedge clk);
      if (mon_clr) begin
        hi_runs.delete(); lo_runs.delete(); addrs.delete();
        hi_len = 0; lo_len = 0; done_cnt = 0; req_cnt = 0; seen_hi = 0;
      end else begin
        if (note_valid === 1'b1) begin
          if (!nv_prev && seen_hi) lo_runs.push_back(lo_len);
          lo_len = 0; hi_len++; seen_hi = 1;
        end else begin
          if (nv_prev) begin hi_runs.push_back(hi_len); hi_len = 0; end
          if (seen_hi) lo_len++;
        end
        if (done === 1'b1) done_cnt++;
        if (mem_req === 1'b1) req_cnt++;
      end
      nv_prev = (note_valid === 1'b1);
      if (force_ack) begin
        mem_ack = 1'b1; mem_data = rom[0];
      end else if (rst || !mem_req || mem_ack) begin
        mem_ack = 1'b0; req_cyc = 0;
      end else begin
        req_cyc++;
        if (req_cyc >= 2 && mem_auto) begin
          mem_ack = 1'b1; mem_data = rom[mem_addr[2:0]];
          addrs.push_back(int'(mem_addr));
        end
      end
    end
  end

  task automatic pulse_start;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic mon_clear;
    mon_clr = 1'b1;
    @(negedge clk); #1;
    mon_clr = 1'b0;
  endtask

  task automatic wait_done;
    for (int i = 0; i < 400 && done_cnt == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0; #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({note_out, note_valid, busy, done, mem_req} !== '0) begin errors++;
      $display("FAIL reset_outputs: got note=%h nv=%b busy=%b done=%b req=%b, expected all 0", note_out, note_valid, busy, done, mem_req); end
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", mem_addr); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    rom[0] = {10'h00C, 8'd3}; rom[1] = {10'h011, 8'd2}; song_len = 2;
    mon_clear(); pulse_start();
    repeat (5) @(negedge clk);
    checks++; if (note_out !== 10'h00C) begin errors++; $display("FAIL basic_note: got %h expected 00c", note_out); end
    song_len = 5;   // must be ignored mid-song
    pulse_start();  // must be ignored while busy
    wait_done();
    checks++; if (hi_runs.size() !== 2) begin errors++; $display("FAIL basic_hi_count: got %0d expected 2", hi_runs.size()); end
    if (hi_runs.size() == 2) begin
      checks++; if (hi_runs[0] !== 12) begin errors++; $display("FAIL basic_hi0: got %0d expected 12", hi_runs[0]); end
      checks++; if (hi_runs[1] !== 8) begin errors++; $display("FAIL basic_hi1: got %0d expected 8", hi_runs[1]); end
    end
    checks++; if (lo_runs.size() < 1 || lo_runs[0] !== 6) begin errors++; $display("FAIL basic_gap: got %0d runs, first %0d expected 6", lo_runs.size(), (lo_runs.size() > 0) ? lo_runs[0] : -1); end
    checks++; if (addrs.size() !== 2 || addrs[0] !== 0 || addrs[1] !== 1) begin errors++; $display("FAIL basic_addrs: got %0d fetches, expected addrs 0,1", addrs.size()); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done: got %0d cycles expected 1", done_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b expected 0", busy); end
  endtask

  task automatic test_skip_zero_dur;
    rom[0] = {10'h00C, 8'd2}; rom[1] = {10'h011, 8'd0}; rom[2] = {10'h022, 8'd1}; song_len = 3;
    mon_clear(); pulse_start(); wait_done();
    checks++; if (hi_runs.size() !== 2) begin errors++; $display("FAIL skip_hi_count: got %0d expected 2", hi_runs.size()); end
    if (hi_runs.size() == 2) begin
      checks++; if (hi_runs[0] !== 8 || hi_runs[1] !== 4) begin errors++; $display("FAIL skip_runs: got %0d,%0d expected 8,4", hi_runs[0], hi_runs[1]); end
    end
    checks++; if (addrs.size() !== 3 || addrs[1] !== 1 || addrs[2] !== 2) begin errors++; $display("FAIL skip_addrs: got %0d fetches expected addrs 0,1,2", addrs.size()); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL skip_done: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_pause;
    rom[0] = {10'h00C, 8'd3}; song_len = 1;
    mon_clear(); pulse_start();
    for (int i = 0; i < 50 && note_valid !== 1'b1; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 5) begin
        checks++; if (note_valid !== 1'b0) begin errors++; $display("FAIL pause_mute: got %b expected 0", note_valid); end
        checks++; if (note_out !== 10'h00C) begin errors++; $display("FAIL pause_hold: got %h expected 00c", note_out); end
      end
    end
    pause = 1'b0;
    wait_done();
    checks++; if (hi_runs.size() !== 2 || lo_runs.size() < 1) begin errors++; $display("FAIL pause_runs: got %0d high runs %0d low runs expected 2 and >=1", hi_runs.size(), lo_runs.size()); end
    else begin
      checks++; if (hi_runs[0] !== 5 || lo_runs[0] !== 10 || hi_runs[1] !== 7) begin errors++;
        $display("FAIL pause_timing: got %0d/%0d/%0d expected 5/10/7", hi_runs[0], lo_runs[0], hi_runs[1]); end
    end
  endtask

  task automatic test_abort;
    rom[0] = {10'h00C, 8'd3}; song_len = 1; mem_auto = 1'b0;
    mon_clear(); pulse_start();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL abort_req_up: got %b expected 1", mem_req); end
    enable = 1'b0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_idle: got req=%b busy=%b expected 0/0", mem_req, busy); end
    force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if ({mem_req, busy, note_valid, note_out} !== '0) begin errors++;
      $display("FAIL abort_late_ack: got req=%b busy=%b nv=%b note=%h expected all 0", mem_req, busy, note_valid, note_out); end
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL abort_no_done: got %0d expected 0", done_cnt); end
    enable = 1'b1; mem_auto = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_loop;
    rom[0] = {10'h022, 8'd1}; song_len = 1; loop_en = 1'b1;
    mon_clear(); pulse_start();
    for (int i = 0; i < 300 && addrs.size() < 3; i++) @(negedge clk);
    checks++; if (addrs.size() < 3) begin errors++; $display("FAIL loop_refetch: got %0d fetches expected 3", addrs.size()); end
    checks++; if (done_cnt !== 0 || busy !== 1'b1) begin errors++; $display("FAIL loop_running: got done=%0d busy=%b expected 0/1", done_cnt, busy); end
    checks++; if (hi_runs.size() < 1 || hi_runs[0] !== 4) begin errors++; $display("FAIL loop_note: got %0d runs first %0d expected 4", hi_runs.size(), (hi_runs.size() > 0) ? hi_runs[0] : -1); end
    loop_en = 1'b0;
    wait_done();
    checks++; if (done_cnt !== 1 || busy !== 1'b0) begin errors++; $display("FAIL loop_exit: got done=%0d busy=%b expected 1/0", done_cnt, busy); end
    foreach (addrs[k]) begin
      checks++; if (addrs[k] !== 0) begin errors++; $display("FAIL loop_addr: fetch %0d got addr %0d expected 0", k, addrs[k]); end
    end
  endtask

  task automatic test_empty_and_rst;
    song_len = 0;
    mon_clear();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++; if (done !== 1'b1 || busy !== 1'b0 || mem_req !== 1'b0) begin errors++;
      $display("FAIL empty_done: got done=%b busy=%b req=%b expected 1/0/0", done, busy, mem_req); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL empty_pulse: got done=%b expected 0", done); end
    repeat (3) @(negedge clk);
    checks++; if (req_cnt !== 0 || done_cnt !== 1) begin errors++; $display("FAIL empty_counts: got req=%0d done=%0d expected 0/1", req_cnt, done_cnt); end

    rom[0] = {10'h00C, 8'd3}; song_len = 1;
    pulse_start();
    for (int i = 0; i < 50 && note_valid !== 1'b1; i++) @(negedge clk);
    checks++; if (note_valid !== 1'b1) begin errors++; $display("FAIL rst_setup: got nv=%b expected 1", note_valid); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({note_out, note_valid, busy, done, mem_req} !== '0 || mem_addr !== '0) begin errors++;
      $display("FAIL rst_async: got note=%h nv=%b busy=%b done=%b req=%b addr=%0d expected all 0", note_out, note_valid, busy, done, mem_req, mem_addr); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    checks = 0; errors = 0;
    enable = 1'b1; start = 1'b0; pause = 1'b0; loop_en = 1'b0; song_len = '0;
    mem_auto = 1'b1; force_ack = 1'b0; mon_clr = 1'b0;
    for (int i = 0; i < 8; i++) rom[i] = '0;
    test_reset();
    test_basic();
    test_skip_zero_dur();
    test_pause();
    test_abort();
    test_loop();
    test_empty_and_rst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
